// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/forwarding controller for a 5-stage MIPS pipeline: shadows EX/MEM/WB
// destination info, resolves HOLD > FLUSH > STALL > RUN and selects ALU forwards.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_inst,
  input  logic             ex_taken,
  input  logic             mem_hold,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HOLD  = 2'd3
  } act_t;

  act_t act;
  act_t state_q;

  logic [5:0] op;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       dec_use_rs, dec_use_rt, dec_wr, dec_ld;
  logic [4:0] dec_dst;
  logic       load_use;
  logic       unused_bits;

  // EX slot also keeps its source registers so forwarding needs no extra decode.
  logic [4:0] ex_dst, ex_rs, ex_rt;
  logic       ex_wr, ex_ld;
  logic [4:0] mem_dst;
  logic       mem_wr, mem_ld;
  logic [4:0] wb_dst;
  logic       wb_wr;

  assign op          = id_inst[31:26];
  assign id_rs       = id_inst[25:21];
  assign id_rt       = id_inst[20:16];
  assign id_rd       = id_inst[15:11];
  assign unused_bits = ^id_inst[10:0];

  always_comb begin
    dec_use_rs = 1'b0;
    dec_use_rt = 1'b0;
    dec_wr     = 1'b0;
    dec_ld     = 1'b0;
    dec_dst    = 5'd0;
    case (op)
      6'h00: begin
        dec_use_rs = 1'b1;
        dec_use_rt = 1'b1;
        dec_wr     = 1'b1;
        dec_dst    = id_rd;
      end
      6'h23: begin
        dec_use_rs = 1'b1;
        dec_wr     = 1'b1;
        dec_ld     = 1'b1;
        dec_dst    = id_rt;
      end
      6'h2B, 6'h04: begin
        dec_use_rs = 1'b1;
        dec_use_rt = 1'b1;
      end
      default: ;
    endcase
    // $0 is hardwired, so a write to it is no write at all.
    if (dec_dst == 5'd0) dec_wr = 1'b0;
  end

  assign load_use = ex_ld && ex_wr &&
                    ((dec_use_rs && (id_rs == ex_dst)) ||
                     (dec_use_rt && (id_rt == ex_dst)));

  always_comb begin
    if (mem_hold)      act = ST_HOLD;
    else if (ex_taken) act = ST_FLUSH;
    else if (load_use) act = ST_STALL;
    else               act = ST_RUN;
  end

  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else begin
      case (act)
        ST_HOLD: ;
        ST_FLUSH: begin
          pc_write    = 1'b1;
          ifid_write  = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end
        ST_STALL: idex_bubble = 1'b1;
        default: begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      endcase
    end
  end

  // A load result is never taken from EX/MEM; the stall pushes its consumer to WB forwarding.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_wr && !mem_ld && (mem_dst == ex_rs)) fwd_a = 2'b10;
    else if (wb_wr && (wb_dst == ex_rs))         fwd_a = 2'b01;
    if (mem_wr && !mem_ld && (mem_dst == ex_rt)) fwd_b = 2'b10;
    else if (wb_wr && (wb_dst == ex_rt))         fwd_b = 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_dst    <= 5'd0;
      ex_rs     <= 5'd0;
      ex_rt     <= 5'd0;
      ex_wr     <= 1'b0;
      ex_ld     <= 1'b0;
      mem_dst   <= 5'd0;
      mem_wr    <= 1'b0;
      mem_ld    <= 1'b0;
      wb_dst    <= 5'd0;
      wb_wr     <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      state_q   <= ST_RUN;
    end else begin
      state_q <= act;
      if (act != ST_HOLD) begin
        mem_dst <= ex_dst;
        mem_wr  <= ex_wr;
        mem_ld  <= ex_ld;
        wb_dst  <= mem_dst;
        wb_wr   <= mem_wr;
        if (act == ST_RUN) begin
          ex_dst <= dec_dst;
          ex_wr  <= dec_wr;
          ex_ld  <= dec_ld;
          ex_rs  <= dec_use_rs ? id_rs : 5'd0;
          ex_rt  <= dec_use_rt ? id_rt : 5'd0;
        end else begin
          ex_dst <= 5'd0;
          ex_wr  <= 1'b0;
          ex_ld  <= 1'b0;
          ex_rs  <= 5'd0;
          ex_rt  <= 5'd0;
        end
      end
      if (act == ST_STALL && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (act == ST_FLUSH && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign state = state_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and forwarding controller for the 5-stage MIPS pipeline. It decodes the IF/ID instruction and keeps a shadow copy of the destination register, register-write flag and load flag for the EX, MEM and WB stages. From these it drives PC/IF-ID write enables, IF/ID flush, ID/EX bubble insertion and ALU operand forwarding selects. It sits beside the pipeline registers and adds saturating stall/flush counters for performance observation.

## Interface
- CNT_W, 16, width of stall and flush event counters.
- clk  in  1  pipeline clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_inst  in  32  instruction currently held in IF/ID.
- ex_taken  in  1  branch in EX resolved taken (zero & pc_control of the EX-stage instruction).
- mem_hold  in  1  data memory not ready; freezes the whole pipeline.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads 32'h0 (nop) at next edge.
- idex_bubble  out  1  ID/EX control field loads all-zero at next edge.
- fwd_a  out  2  EX operand A source: 00 regfile, 10 EX/MEM ALU result, 01 MEM/WB write data.
- fwd_b  out  2  EX operand B source, same encoding.
- state  out  2  last action: 0 RUN, 1 STALL, 2 FLUSH, 3 HOLD.
- stall_cnt  out  CNT_W  load-use stall cycles, saturating.
- flush_cnt  out  CNT_W  taken-branch flushes, saturating.

## Operation
- Decode of id_inst (op = [31:26]):
  - 0x00 R-type: uses rs, rt; writes rd.
  - 0x23 lw: uses rs; writes rt; load flag set.
  - 0x2B sw: uses rs, rt; no write.
  - 0x04 beq: uses rs, rt; no write.
  - Any other op: uses nothing, no write.
- A write to register 0 is recorded as no-write. Register 0 never causes a hazard or a forward.
- Shadow slots EX, MEM, WB each hold {dst[4:0], wr, ld}.
- Decision priority, evaluated combinationally every cycle:
  1. **mem_hold=1 → HOLD.** pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0. All shadow slots hold.
  2. **ex_taken=1 → FLUSH.** pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1. EX slot gets a bubble; MEM←EX, WB←MEM. flush_cnt increments.
  3. **Load-use → STALL.** Load-use means EX.ld=1, EX.wr=1, and EX.dst equals a used rs/rt of id_inst. Outputs: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0. EX slot gets a bubble; MEM←EX, WB←MEM. stall_cnt increments.
  4. **Otherwise RUN.** pc_write=1, ifid_write=1, others 0. EX←decoded id_inst; MEM←EX, WB←MEM.
- Forwarding uses the rs/rt of the instruction in EX, so the EX slot also stores the src regs of its instruction.
  - fwd_a = 10 if MEM.wr and MEM.dst==EX.rs; else 01 if WB.wr and WB.dst==EX.rs; else 00.
  - fwd_b uses the same rule on EX.rt. The MEM match always wins over the WB match.
- A load in MEM is never forwarded with 10. The stall guarantees a load consumer is separated by a bubble and takes 01.
- Counters saturate at 2^CNT_W−1 and do not wrap.
- state registers the action taken in the cycle just completed.

## Timing
- pc_write, ifid_write, ifid_flush and idex_bubble are combinational from id_inst, ex_taken, mem_hold and the shadow registers. They must settle before the rising edge.
- fwd_a and fwd_b are combinational from shadow registers only; they have no input-to-output path.
- Load-use penalty is exactly 1 cycle. Taken-branch penalty is 2 squashed instructions, flushed in a single edge.
- mem_hold is held across any number of cycles with no state change and no counter change. A pending ex_taken or load-use is acted on in the first cycle after mem_hold drops.
- While rst is low (asynchronous): all shadow slots are cleared to no-write, counters=0, state=RUN. Outputs are pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, fwd_a=fwd_b=00.
- Release of rst takes effect at the first rising edge after deassertion. Reset mid-stall or mid-flush discards all pending hazard state.

## Test plan
- **Reset:** drive rst=0 mid-run with id_inst=0x00441820 → outputs immediately pc_write=0, ifid_flush=1, idex_bubble=1, fwd 00, counters 0, state 0.
- **Load-use:** id_inst 0x8C220000 (lw $2,0($1)) then 0x00441820 (add $3,$2,$4).
  - Stall cycle: pc_write=0, ifid_write=0, idex_bubble=1, state=1, stall_cnt=1.
  - Next cycle: add enters EX and fwd_a=01.
- **ALU forward:** 0x00211020 (add $2,$1,$1) then 0x00421822 (sub $3,$2,$2) → no stall; when sub is in EX, fwd_a=fwd_b=10.
- **Branch:** ex_taken=1 for one cycle → pc_write=1, ifid_flush=1, idex_bubble=1, flush_cnt=1, state=2.
  - Next two EX slots are bubbles; fwd stays 00.
- **Hold priority:** set up the load-use pair plus mem_hold=1 for 3 cycles, then ex_taken=1 together with mem_hold=1.
  - During hold: all enables 0, state=3, counters unchanged.
  - After release: FLUSH is taken (branch beats stall), flush_cnt=1, stall_cnt=0.
- **Register 0:** 0x8C200000 (lw $0) then 0x00002820 (add $5,$0,$0) → no stall, fwd_a=fwd_b=00.
  - With CNT_W=2, 5 back-to-back load-use stalls leave stall_cnt=3.
